spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI mode-0 slave, the far end of the keypad/SPI master link: receives key-code bytes on a
//  display/decoder board. SCLK, MOSI and SS_n are oversampled in the local clk domain.
//  Assembles DATA_W-bit words and presents them with a valid/ack handshake.
//  Shifts a reply word out on MISO (full duplex); flags overrun when a word is not consumed.
// PARAMETERS
//  DATA_W       8  bits per word; also the bit-counter wrap point
//  SYNC_STAGES  2  flops in each input synchronizer (min 2)
//  MSB_FIRST    1  1: MSB first on MOSI and MISO; 0: LSB first
// PORTS
//  clk       in   1       system clock; must be >= 8x SCLK frequency
//  rst       in   1       synchronous reset, active-high
//  sclk      in   1       SPI clock from master, async; idles low (CPOL=0)
//  mosi      in   1       SPI data from master, async
//  ss_n      in   1       SPI select, active-low, async
//  miso      out  1       SPI data to master; driven 0 while deselected (no tristate here)
//  tx_data   in   DATA_W  reply word; sampled at each word start
//  rx_data   out  DATA_W  last received word; stable while rx_valid=1
//  rx_valid  out  1       high from word completion until the cycle rx_ack is seen
//  rx_ack    in   1       consumer accepts rx_data; honoured only while rx_valid=1
//  overrun   out  1       sticky; set when a word completes while rx_valid=1; cleared by rst only
//  busy      out  1       1 while state=SHIFT
// BEHAVIOUR
//  - Reset values: miso=0, rx_data=0, rx_valid=0, overrun=0, busy=0, bit_cnt=0, state=RESYNC.
//  - Inputs pass through SYNC_STAGES flops. Edge detect on synced sclk (rise/fall) and ss_n (fall).
//  - FSM (registered state):
//    RESYNC: wait for synced ss_n=1, then IDLE. Prevents joining a frame mid-word after reset.
//    IDLE:   on ss_n falling edge, latch tx_data into tx_shift and drive its first bit onto miso
//            in the same cycle as the transition, bit_cnt=0, go to SHIFT.
//    SHIFT:  sclk rise: shift synced mosi into rx_shift, bit_cnt++.
//            sclk fall: advance tx_shift and drive the next bit onto miso.
//            When bit_cnt reaches DATA_W: the completed word goes to rx_data (see handshake),
//            bit_cnt=0, tx_data is re-latched for the next word in the same frame, and the
//            state stays SHIFT.
//            If synced ss_n=1: go to IDLE, discard any partial word, bit_cnt=0, miso=0.
//  - Handshake and latency: rx_valid rises 1 clk after the clk in which the DATA_W-th sclk rise
//    is detected. rx_ack with rx_valid=1 clears rx_valid on the next clk.
//  - Word completing while rx_valid=1 and rx_ack=0: the new word is dropped, rx_data is kept,
//    and overrun is set.
//  - Word completing in the same cycle as rx_ack: the new word loads rx_data, rx_valid stays 1,
//    and no overrun is flagged.
//  - rx_ack while rx_valid=0 is ignored.
//  - sclk edge in the same clk as ss_n rising: ss_n wins, the edge is ignored.
//  - rst mid-frame: all state cleared, go to RESYNC, no rx_valid for the partial word.
//  - bit_cnt width is $clog2(DATA_W+1). Compares are unsigned; no other arithmetic.
// STRUCTURE
//  - spi_pkg: state encoding (RESYNC=2'b00, IDLE=2'b01, SHIFT=2'b10), SPI mode constants,
//    default DATA_W.
//  - One sub-module, spi_sync_edge: N-flop synchronizer with rise/fall pulse outputs.
//    Instantiated for sclk and ss_n; mosi uses the same synchronizer with edges unused.
//  - Top: FSM, rx/tx shift registers, bit counter, handshake/overrun logic.
// TESTING
//  - Reset then ss_n low, MOSI 8'hA5 MSB-first, tx_data=8'h3C
//    -> rx_data=8'hA5, one rx_valid rise, MISO carries 8'h3C bit-exact.
//  - Two words 8'h12, 8'h34 in one frame, rx_ack after each
//    -> two valid events in order, overrun=0, second MISO word = tx_data value at word boundary.
//  - Word 8'h55 not acked, then word 8'hAA
//    -> rx_data stays 8'h55, overrun=1 and remains 1 after rx_ack.
//  - ss_n high after 5 bits, then full frame 8'hC3
//    -> no valid for the partial word; next rx_data=8'hC3.
//  - rst asserted mid-word with ss_n held low and clocks continuing
//    -> no rx_valid until ss_n goes high then low; next word 8'h81 received correctly.
//  - rx_ack in the same clk as word 8'h7E completes
//    -> rx_valid stays 1, rx_data=8'h7E, overrun=0.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and mode constants for the SPI slave receiver
package spi_pkg;
    typedef enum logic [1:0] {
        RESYNC = 2'b00,
        IDLE   = 2'b01,
        SHIFT  = 2'b10
    } state_t;
    localparam int DEF_DATA_W = 8;
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with single-cycle rise/fall pulses on the synced level
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end
    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI mode-0 slave; receives words with valid/ack handshake
// and shifts a reply word out on miso, flagging overrun on unconsumed words.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              overrun,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    state_t state;
    logic [CW-1:0] bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, rx_next;
    logic sclk_s, sclk_rise, sclk_fall, ss_s, ss_rise, ss_fall, mosi_s, word_done;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .clk(clk), .rst(rst), .d(ss_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(), .fall()
    );

    function automatic logic tx_bit(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    assign rx_next   = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};
    // a deselect in the same clk as an sclk edge suppresses the edge
    assign word_done = (state == SHIFT) && !ss_s && sclk_rise && (bit_cnt == LAST);

    // tx_shift holds the bits not yet driven; miso holds the bit currently on the wire
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESYNC;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            miso     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                RESYNC: if (ss_s) state <= IDLE;
                IDLE: if (ss_fall) begin
                    state    <= SHIFT;
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    tx_shift <= tx_adv(tx_data);
                    miso     <= tx_bit(tx_data);
                end
                SHIFT: if (ss_s) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    miso    <= 1'b0;
                end else if (sclk_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
                    if (bit_cnt == LAST) tx_shift <= tx_data;
                end else if (sclk_fall) begin
                    miso     <= tx_bit(tx_shift);
                    tx_shift <= tx_adv(tx_shift);
                end
                default: state <= RESYNC;
            endcase
            if (word_done && (!rx_valid || rx_ack)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (word_done) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed scenario tests for the SPI slave receiver
module tb_spi_slave_rx;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic ss_n = 1'b1;
    logic miso;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ack = 1'b0;
    logic overrun;
    logic busy;

    int checks = 0;
    int errors = 0;
    int rises = 0;
    logic pv = 1'b0;
    logic [7:0] m0, m1;
    int r0;

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid && !pv) rises++;
        pv = rx_valid;
    end

    task automatic send_bits(input logic [7:0] v, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = v[i];
            repeat (HALF) @(negedge clk);
            m[i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic ss_lo();
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_hi();
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk) rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_single();
        r0 = rises;
        tx_data = 8'h3C;
        ss_lo();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        send_bits(8'hA5, 8, m0);
        ss_hi();
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data got %h exp a5", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_rx_valid got %b exp 1", rx_valid); end
        checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL single_valid_rises got %0d exp 1", rises - r0); end
        checks++; if (m0 !== 8'h3C) begin errors++; $display("FAIL single_miso_word got %h exp 3c", m0); end
        checks++; if (miso !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_deselect got miso=%b busy=%b exp 0 0", miso, busy); end
        ack();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_ack_clear got %b exp 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        r0 = rises;
        tx_data = 8'h11;
        ss_lo();
        tx_data = 8'h22;
        send_bits(8'h12, 8, m0);
        checks++; if (rx_data !== 8'h12 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_word1 got %h/%b exp 12/1", rx_data, rx_valid); end
        ack();
        send_bits(8'h34, 8, m1);
        checks++; if (rx_data !== 8'h34 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_word2 got %h/%b exp 34/1", rx_data, rx_valid); end
        ack();
        ss_hi();
        checks++; if (rises - r0 !== 2) begin errors++; $display("FAIL b2b_valid_rises got %0d exp 2", rises - r0); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
        checks++; if (m0 !== 8'h11) begin errors++; $display("FAIL b2b_miso1 got %h exp 11", m0); end
        checks++; if (m1 !== 8'h22) begin errors++; $display("FAIL b2b_miso2 got %h exp 22", m1); end
    endtask

    task automatic test_overrun();
        ss_lo();
        send_bits(8'h55, 8, m0);
        send_bits(8'hAA, 8, m0);
        ss_hi();
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL ovr_rx_data got %h exp 55", rx_data); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid got %b exp 1", rx_valid); end
        ack();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear got %b exp 0", rx_valid); end
        do_reset();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_rst_clear got %b exp 0", overrun); end
    endtask

    task automatic test_partial();
        r0 = rises;
        ss_lo();
        send_bits(8'hFF, 5, m0);
        ss_hi();
        checks++; if (rx_valid !== 1'b0 || rises != r0) begin errors++; $display("FAIL partial_no_valid got %b rises %0d exp 0 0", rx_valid, rises - r0); end
        ss_lo();
        send_bits(8'hC3, 8, m0);
        ss_hi();
        checks++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin errors++; $display("FAIL partial_next got %h/%b exp c3/1", rx_data, rx_valid); end
        ack();
    endtask

    task automatic test_reset_mid();
        ss_lo();
        send_bits(8'hF0, 3, m0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r0 = rises;
        send_bits(8'hFF, 5, m0);
        send_bits(8'h99, 8, m0);
        repeat (HALF) @(negedge clk);
        checks++; if (rx_valid !== 1'b0 || rises != r0) begin errors++; $display("FAIL rstmid_no_valid got %b rises %0d exp 0 0", rx_valid, rises - r0); end
        checks++; if (rx_data !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got %h/%b exp 00/0", rx_data, busy); end
        ss_hi();
        ss_lo();
        send_bits(8'h81, 8, m0);
        ss_hi();
        checks++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_next got %h/%b exp 81/1", rx_data, rx_valid); end
        ack();
    endtask

    task automatic test_ack_same_clk();
        ss_lo();
        send_bits(8'h11, 8, m0);
        checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("FAIL samack_pre got %h/%b exp 11/1", rx_data, rx_valid); end
        send_bits(8'h7E, 7, m0);
        r0 = rises;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        checks++; if (rx_valid !== 1'b1 || rises != r0) begin errors++; $display("FAIL samack_valid got %b rises %0d exp 1 0", rx_valid, rises - r0); end
        checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL samack_rx_data got %h exp 7e", rx_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL samack_overrun got %b exp 0", overrun); end
        ss_hi();
        ack();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_partial();
        test_reset_mid();
        test_ack_same_clk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
